// File: rtl/key_filter_pkg.sv
// Shared types and helpers for the multi-channel key debouncer.
// Holds the per-channel FSM state encoding and the counter-width helper.
package key_filter_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } key_state_e;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_filter_chan.sv
// One key channel: 2-FF synchroniser, debounce FSM, hold counter for long press,
// and registered level/press/release/long outputs.
module key_filter_chan
    import key_filter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned LONG_CYCLES     = 1000,
    parameter int unsigned REPEAT_CYCLES   = 0,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned CNT_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = cnt_width(LONG_CYCLES + REPEAT_CYCLES);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_TOP  = HOLD_W'(LONG_CYCLES + REPEAT_CYCLES);
    localparam logic              REL_LVL   = ACTIVE_LOW;

    logic [1:0]        sync_q;
    key_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_next;
    logic              press_d, release_d, long_d, long_hit;
    logic              pressed;

    assign pressed = sync_q[1] ^ REL_LVL;

    // With repeat enabled the counter folds back to LONG+1 after each repeat
    // pulse; without it the counter parks at LONG.
    always_comb begin
        hold_next = hold_q + 1'b1;
        if (REPEAT_CYCLES != 0 && hold_q == HOLD_TOP) begin
            hold_next = HOLD_LONG + 1'b1;
        end else if (REPEAT_CYCLES == 0 && hold_q == HOLD_LONG) begin
            hold_next = hold_q;
        end
        long_hit = (hold_next == HOLD_LONG && hold_q != HOLD_LONG) ||
                   (REPEAT_CYCLES != 0 && hold_next == HOLD_TOP);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                hold_d = '0;
                if (pressed) begin
                    state_d = PRESS_DB;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_DB: begin
                if (!pressed) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    hold_d  = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                hold_d = hold_next;
                long_d = long_hit;
                if (!pressed) begin
                    state_d = RELEASE_DB;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_DB: begin
                hold_d = hold_next;
                if (pressed) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    hold_d    = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= {2{REL_LVL}};
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], key_in};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            key_level   <= (state_d == PRESSED) || (state_d == RELEASE_DB);
            key_press   <= press_d;
            key_release <= release_d;
            key_long    <= long_d;
        end
    end

endmodule

// File: rtl/key_filter_multi.sv
// Multi-channel key debouncer: NUM_KEYS independent key_filter_chan instances
// with their outputs packed into per-key vectors.
module key_filter_multi
    import key_filter_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned LONG_CYCLES     = 1000,
    parameter int unsigned REPEAT_CYCLES   = 0,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_filter_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .key_in      (key_in[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_filter_multi.sv
// Directed bench for key_filter_multi: clean press, bounce, release bounce, short press,
// channel independence and reset mid-hold, with hand-computed latencies.
module tb_key_filter_multi;

    localparam int unsigned NK = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key_in = '1;
    logic [NK-1:0] key_level, key_press, key_release, key_long;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int press_tot[NK] = '{default: 0};
    int rel_tot[NK]   = '{default: 0};
    int long_tot[NK]  = '{default: 0};
    int fall_tot[NK]  = '{default: 0};
    int press_at[NK]  = '{default: 0};
    int rel_at[NK]    = '{default: 0};
    int long_at[NK]   = '{default: 0};
    int coincide_tot  = 0;
    logic [NK-1:0] level_prev = '0;

    int t0, t1, p0, p1, r0, r1, l0, f0;

    key_filter_multi #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (16),
        .REPEAT_CYCLES   (8),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < NK; k++) begin
            if (key_press[k]) begin
                press_tot[k] = press_tot[k] + 1;
                press_at[k]  = cyc;
            end
            if (key_release[k]) begin
                rel_tot[k] = rel_tot[k] + 1;
                rel_at[k]  = cyc;
            end
            if (key_long[k]) begin
                long_tot[k] = long_tot[k] + 1;
                long_at[k]  = cyc;
            end
            if (level_prev[k] && !key_level[k]) fall_tot[k] = fall_tot[k] + 1;
            if (key_press[k] && key_long[k]) coincide_tot = coincide_tot + 1;
        end
        level_prev = key_level;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Actions happen one time unit after a falling edge, well before the next rising edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_key0(input logic val, input int n);
        key_in[0] = val;
        wait_cyc(n);
    endtask

    initial begin
        // Reset state
        wait_cyc(3);
        check_eq("rst_level",   int'(key_level),   0);
        check_eq("rst_press",   int'(key_press),   0);
        check_eq("rst_release", int'(key_release), 0);
        check_eq("rst_long",    int'(key_long),    0);
        rst = 1'b0;
        wait_cyc(5);
        check_eq("idle_level", int'(key_level), 0);

        // 1. Clean press held 40 cycles, long pulses at hold 16/24/32
        p0 = press_tot[0]; l0 = long_tot[0];
        key_in[0] = 1'b0; t0 = cyc;
        wait_cyc(25);
        check_eq("t1_long_first_cnt", long_tot[0] - l0, 1);
        check_eq("t1_long_first_at",  long_at[0] - t0, 22);
        wait_cyc(15);
        check_eq("t1_press_cnt", press_tot[0] - p0, 1);
        check_eq("t1_press_lat", press_at[0] - t0, 6);
        check_eq("t1_level",     int'(key_level[0]), 1);
        check_eq("t1_long_cnt",  long_tot[0] - l0, 3);
        check_eq("t1_long_last", long_at[0] - t0, 38);
        r0 = rel_tot[0];
        key_in[0] = 1'b1; t1 = cyc;
        wait_cyc(12);
        check_eq("t1_rel_cnt",   rel_tot[0] - r0, 1);
        check_eq("t1_rel_lat",   rel_at[0] - t1, 6);
        check_eq("t1_rel_level", int'(key_level[0]), 0);
        check_eq("t1_rel_long",  long_tot[0] - l0, 3);

        // 2. Press bounce then steady low
        p0 = press_tot[0];
        set_key0(1'b0, 2); set_key0(1'b1, 3);
        set_key0(1'b0, 3); set_key0(1'b1, 2);
        set_key0(1'b0, 2); set_key0(1'b1, 3);
        check_eq("t2_no_bounce_press", press_tot[0] - p0, 0);
        key_in[0] = 1'b0; t0 = cyc;
        wait_cyc(12);
        check_eq("t2_press_cnt", press_tot[0] - p0, 1);
        check_eq("t2_press_lat", press_at[0] - t0, 6);

        // 3. Release with glitches back to low
        p0 = press_tot[0]; r0 = rel_tot[0]; f0 = fall_tot[0];
        set_key0(1'b1, 2); set_key0(1'b0, 2);
        set_key0(1'b1, 2); set_key0(1'b0, 2);
        set_key0(1'b1, 2); set_key0(1'b0, 2);
        check_eq("t3_level_held", int'(key_level[0]), 1);
        check_eq("t3_no_fall", fall_tot[0] - f0, 0);
        key_in[0] = 1'b1; t1 = cyc;
        wait_cyc(12);
        check_eq("t3_rel_cnt",   rel_tot[0] - r0, 1);
        check_eq("t3_rel_lat",   rel_at[0] - t1, 6);
        check_eq("t3_fall_cnt",  fall_tot[0] - f0, 1);
        check_eq("t3_press_cnt", press_tot[0] - p0, 0);

        // 4. Short press, no long pulse
        p0 = press_tot[0]; r0 = rel_tot[0]; l0 = long_tot[0];
        key_in[0] = 1'b0; t0 = cyc;
        wait_cyc(10);
        key_in[0] = 1'b1; t1 = cyc;
        wait_cyc(12);
        check_eq("t4_press_lat", press_at[0] - t0, 6);
        check_eq("t4_press_cnt", press_tot[0] - p0, 1);
        check_eq("t4_rel_lat",   rel_at[0] - t1, 6);
        check_eq("t4_long_cnt",  long_tot[0] - l0, 0);

        // 5. Independence: key 1 bounces, both released together
        p0 = press_tot[0]; p1 = press_tot[1]; r0 = rel_tot[0]; r1 = rel_tot[1];
        key_in = 2'b00; t0 = cyc;
        wait_cyc(2);
        key_in[1] = 1'b1;
        wait_cyc(2);
        key_in[1] = 1'b0;
        wait_cyc(10);
        check_eq("t5_k0_press_lat", press_at[0] - t0, 6);
        check_eq("t5_k1_press_lat", press_at[1] - t0, 10);
        check_eq("t5_k0_press_cnt", press_tot[0] - p0, 1);
        check_eq("t5_k1_press_cnt", press_tot[1] - p1, 1);
        key_in = 2'b11; t1 = cyc;
        wait_cyc(10);
        check_eq("t5_k0_rel_lat", rel_at[0] - t1, 6);
        check_eq("t5_k1_rel_lat", rel_at[1] - t1, 6);
        check_eq("t5_k0_rel_cnt", rel_tot[0] - r0, 1);
        check_eq("t5_k1_rel_cnt", rel_tot[1] - r1, 1);

        // 6. Reset while held; fresh press after deassertion, no release
        key_in[0] = 1'b0;
        wait_cyc(12);
        check_eq("t6_level_before", int'(key_level[0]), 1);
        rst = 1'b1;
        #1;
        check_eq("t6_level_async", int'(key_level), 0);
        wait_cyc(3);
        check_eq("t6_level_in_rst", int'(key_level), 0);
        p0 = press_tot[0]; r0 = rel_tot[0];
        rst = 1'b0; t1 = cyc;
        wait_cyc(12);
        check_eq("t6_press_cnt", press_tot[0] - p0, 1);
        check_eq("t6_press_lat", press_at[0] - t1, 6);
        check_eq("t6_rel_cnt",   rel_tot[0] - r0, 0);
        check_eq("t6_level",     int'(key_level[0]), 1);
        key_in[0] = 1'b1;
        wait_cyc(12);

        check_eq("press_long_coincide", coincide_tot, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
